// File: rtl/apu_shared_dispatch_pkg.sv
// Shared constants and types for the APU cluster: core count, FP width,
// add/sub unit latency and flag widths, and the issue-tag record.
package apu_cluster_package;

  localparam int unsigned C_NB_CORES         = 8;
  localparam int unsigned FP_WIDTH           = 32;
  localparam int unsigned C_ADDSUB_PIPE_REGS = 1;
  localparam int unsigned WOP_ADDSUB         = 1;
  localparam int unsigned NDSFLAGS_ADDSUB    = 3;
  localparam int unsigned NUSFLAGS_ADDSUB    = 8;

  // Wide enough for the 16-core maximum.
  localparam int unsigned TAG_IDX_W = 4;

  typedef struct packed {
    logic                 valid;
    logic [TAG_IDX_W-1:0] idx;
  } tag_t;

endpackage

// File: rtl/apu_shared_dispatch_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester found
// starting at ptr_i and wrapping past the last core.
module rr_arbiter #(
  parameter int unsigned NCORES = 8,
  parameter int unsigned IW     = (NCORES > 1) ? $clog2(NCORES) : 1
) (
  input  logic [NCORES-1:0] req_i,
  input  logic [IW-1:0]     ptr_i,
  output logic [NCORES-1:0] gnt_o,
  output logic [IW-1:0]     idx_o
);

  logic        found;
  int unsigned cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned i = 0; i < NCORES; i++) begin
      cand = (32'(ptr_i) + i) % NCORES;
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/apu_shared_dispatch.sv
// Shares one fixed-latency FP unit among NCORES cores: round-robin issue,
// a tag shift register routes each result back to its requesting core.
module apu_shared_dispatch
  import apu_cluster_package::*;
#(
  parameter int unsigned NCORES    = C_NB_CORES,
  parameter int unsigned PIPE_REGS = C_ADDSUB_PIPE_REGS,
  parameter int unsigned WOP       = WOP_ADDSUB,
  parameter int unsigned NDSFLAGS  = NDSFLAGS_ADDSUB,
  parameter int unsigned NUSFLAGS  = NUSFLAGS_ADDSUB
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NCORES-1:0]                  core_req_i,
  output logic [NCORES-1:0]                  core_gnt_o,
  input  logic [NCORES-1:0][FP_WIDTH-1:0]    core_opa_i,
  input  logic [NCORES-1:0][FP_WIDTH-1:0]    core_opb_i,
  input  logic [NCORES-1:0][WOP-1:0]         core_op_i,
  input  logic [NCORES-1:0][NDSFLAGS-1:0]    core_flags_i,
  output logic [NCORES-1:0]                  core_rvalid_o,
  output logic [FP_WIDTH-1:0]                core_result_o,
  output logic [NUSFLAGS-1:0]                core_rflags_o,
  output logic                               unit_valid_o,
  output logic [FP_WIDTH-1:0]                unit_opa_o,
  output logic [FP_WIDTH-1:0]                unit_opb_o,
  output logic [WOP-1:0]                     unit_op_o,
  output logic [NDSFLAGS-1:0]                unit_flags_o,
  input  logic [FP_WIDTH-1:0]                unit_result_i,
  input  logic [NUSFLAGS-1:0]                unit_flags_i,
  output logic                               busy_o
);

  localparam int unsigned IW = (NCORES > 1) ? $clog2(NCORES) : 1;

  logic [NCORES-1:0] req_m;
  logic [NCORES-1:0] gnt;
  logic [IW-1:0]     gnt_idx;
  logic              gnt_any;
  logic [IW-1:0]     ptr_q, ptr_d;
  tag_t              tags_q [PIPE_REGS];
  tag_t              tags_d [PIPE_REGS];
  tag_t              tag_last;

  // Masking requests under reset keeps grants and issue quiet during reset.
  assign req_m   = rst_i ? '0 : core_req_i;
  assign gnt_any = |gnt;

  rr_arbiter #(
    .NCORES (NCORES),
    .IW     (IW)
  ) u_arb (
    .req_i (req_m),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) begin
      ptr_d = (32'(gnt_idx) == NCORES - 1) ? '0 : IW'(32'(gnt_idx) + 1);
    end
    tags_d[0] = '{valid: gnt_any, idx: TAG_IDX_W'(gnt_idx)};
    for (int unsigned i = 1; i < PIPE_REGS; i++) begin
      tags_d[i] = tags_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
      for (int unsigned i = 0; i < PIPE_REGS; i++) begin
        tags_q[i] <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      for (int unsigned i = 0; i < PIPE_REGS; i++) begin
        tags_q[i] <= tags_d[i];
      end
    end
  end

  assign core_gnt_o   = gnt;
  assign unit_valid_o = gnt_any;
  assign unit_opa_o   = gnt_any ? core_opa_i[gnt_idx]   : '0;
  assign unit_opb_o   = gnt_any ? core_opb_i[gnt_idx]   : '0;
  assign unit_op_o    = gnt_any ? core_op_i[gnt_idx]    : '0;
  assign unit_flags_o = gnt_any ? core_flags_i[gnt_idx] : '0;

  assign tag_last      = tags_q[PIPE_REGS-1];
  assign core_result_o = unit_result_i;
  assign core_rflags_o = unit_flags_i;

  always_comb begin
    core_rvalid_o = '0;
    busy_o        = 1'b0;
    if (!rst_i) begin
      if (tag_last.valid) begin
        core_rvalid_o[tag_last.idx[IW-1:0]] = 1'b1;
      end
      for (int unsigned i = 0; i < PIPE_REGS; i++) begin
        busy_o = busy_o | tags_q[i].valid;
      end
    end
  end

endmodule

// File: tb/tb_apu_shared_dispatch.sv
// Scoreboard bench for apu_shared_dispatch with a behavioural shared unit
// (result = opa ^ opb) delayed by PIPE cycles.
module tb_apu_shared_dispatch;
  import apu_cluster_package::*;

  localparam int unsigned N    = 8;
  localparam int unsigned PIPE = 5;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [N-1:0]         core_req;
  logic [N-1:0]         core_gnt;
  logic [N-1:0][31:0]   core_opa, core_opb;
  logic [N-1:0][0:0]    core_op;
  logic [N-1:0][2:0]    core_flags;
  logic [N-1:0]         core_rvalid;
  logic [31:0]          core_result;
  logic [7:0]           core_rflags;
  logic                 unit_valid;
  logic [31:0]          unit_opa, unit_opb;
  logic [0:0]           unit_op;
  logic [2:0]           unit_flags;
  logic [31:0]          unit_result;
  logic [7:0]           unit_rflags;
  logic                 busy;

  always #5 clk = ~clk;

  apu_shared_dispatch #(
    .NCORES    (N),
    .PIPE_REGS (PIPE),
    .WOP       (1),
    .NDSFLAGS  (3),
    .NUSFLAGS  (8)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .core_req_i    (core_req),
    .core_gnt_o    (core_gnt),
    .core_opa_i    (core_opa),
    .core_opb_i    (core_opb),
    .core_op_i     (core_op),
    .core_flags_i  (core_flags),
    .core_rvalid_o (core_rvalid),
    .core_result_o (core_result),
    .core_rflags_o (core_rflags),
    .unit_valid_o  (unit_valid),
    .unit_opa_o    (unit_opa),
    .unit_opb_o    (unit_opb),
    .unit_op_o     (unit_op),
    .unit_flags_o  (unit_flags),
    .unit_result_i (unit_result),
    .unit_flags_i  (unit_rflags),
    .busy_o        (busy)
  );

  // Shared unit model: fixed PIPE-cycle latency.
  logic [31:0] upipe_r [PIPE];
  logic [7:0]  upipe_f [PIPE];
  always @(posedge clk) begin
    upipe_r[0] <= unit_opa ^ unit_opb;
    upipe_f[0] <= {4'b1010, unit_flags, unit_op};
    for (int i = 1; i < PIPE; i++) begin
      upipe_r[i] <= upipe_r[i-1];
      upipe_f[i] <= upipe_f[i-1];
    end
  end
  assign unit_result = upipe_r[PIPE-1];
  assign unit_rflags = upipe_f[PIPE-1];

  typedef struct {
    int unsigned core;
    logic [31:0] res;
    logic [7:0]  fl;
    int unsigned issued;
    int unsigned due;
  } exp_t;

  exp_t        q[$];
  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] exp_opa(input int unsigned k);
    return 32'h3f80_0000 + k;
  endfunction

  function automatic logic [31:0] exp_opb(input int unsigned k);
    return 32'h4000_0000 + (k << 8);
  endfunction

  // Monitor: pops an expectation whenever the DUT presents a result.
  always @(negedge clk) begin
    exp_t        e;
    logic        busy_exp;
    logic [7:0]  mask;
    if (rst) begin
      chk("rvalid_in_reset", 32'(core_rvalid), 32'h0);
      chk("busy_in_reset", 32'(busy), 32'h0);
    end else begin
      busy_exp = 1'b0;
      foreach (q[i]) if (q[i].issued < cyc) busy_exp = 1'b1;
      chk("busy", 32'(busy), 32'(busy_exp));
      if (|core_rvalid) begin
        if (q.size() == 0) begin
          chk("spurious_rvalid", 32'(core_rvalid), 32'h0);
        end else begin
          e    = q.pop_front();
          mask = 8'(1 << e.core);
          chk("rvalid_core", 32'(core_rvalid), 32'(mask));
          chk("rvalid_latency", cyc, e.due);
          chk("result", core_result, e.res);
          chk("rflags", 32'(core_rflags), 32'(e.fl));
        end
      end else if (q.size() > 0 && q[0].due <= cyc) begin
        e    = q.pop_front();
        mask = 8'(1 << e.core);
        chk("rvalid_missing", 32'(core_rvalid), 32'(mask));
      end
    end
  end

  // One cycle of requests; exp_idx < 0 means no grant is expected.
  task automatic cycle_req(input logic [7:0] req, input int exp_idx);
    exp_t       e;
    logic [7:0] mask;
    core_req = req;
    @(negedge clk);
    if (exp_idx >= 0) begin
      mask = 8'(1 << exp_idx);
      chk("gnt", 32'(core_gnt), 32'(mask));
      chk("unit_valid", 32'(unit_valid), 32'h1);
      chk("unit_opa", unit_opa, exp_opa(exp_idx));
      chk("unit_opb", unit_opb, exp_opb(exp_idx));
      chk("unit_opflags", 32'({unit_flags, unit_op}), 32'({exp_idx[2:0], exp_idx[0]}));
      e.core   = exp_idx;
      e.res    = exp_opa(exp_idx) ^ exp_opb(exp_idx);
      e.fl     = {4'b1010, exp_idx[2:0], exp_idx[0]};
      e.issued = cyc;
      e.due    = cyc + PIPE;
      q.push_back(e);
    end else begin
      chk("gnt_idle", 32'(core_gnt), 32'h0);
      chk("unit_valid_idle", 32'(unit_valid), 32'h0);
      chk("unit_data_idle", unit_opa | unit_opb | 32'({unit_flags, unit_op}), 32'h0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int unsigned n, input logic [7:0] req);
    rst      = 1'b1;
    core_req = req;
    q.delete();
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      chk("gnt_in_reset", 32'(core_gnt), 32'h0);
      chk("unit_valid_in_reset", 32'(unit_valid), 32'h0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < N; k++) begin
      core_opa[k]   = exp_opa(k);
      core_opb[k]   = exp_opb(k);
      core_op[k]    = 1'(k);
      core_flags[k] = 3'(k);
    end
    core_req = 8'hFF;
    @(posedge clk);
    #1;
    do_reset(3, 8'hFF);

    // Single request from core 0; ptr -> 1.
    cycle_req(8'h01, 0);
    for (int i = 0; i < PIPE + 1; i++) cycle_req(8'h00, -1);

    // Move ptr to 0, then all cores requesting for 16 cycles.
    cycle_req(8'h80, 7);
    for (int i = 0; i < 16; i++) cycle_req(8'hFF, i % 8);

    // ptr -> 6, then cores 6 and 0 contend across the wrap.
    cycle_req(8'h20, 5);
    cycle_req(8'h41, 6);
    cycle_req(8'h41, 0);
    cycle_req(8'h41, 6);

    // Three issues in flight (ptr=7), then reset drops them.
    cycle_req(8'hFF, 7);
    cycle_req(8'hFF, 0);
    cycle_req(8'hFF, 1);
    do_reset(1, 8'h00);
    for (int i = 0; i < PIPE + 3; i++) cycle_req(8'h00, -1);

    // After reset ptr=0; a request from all cores must start at core 0.
    cycle_req(8'hFF, 0);
    cycle_req(8'h04, 2);
    for (int i = 0; i < 10; i++) cycle_req(8'h00, -1);
    cycle_req(8'hFF, 3);

    // Lone requester gets back-to-back grants.
    cycle_req(8'h08, 3);
    cycle_req(8'h08, 3);
    cycle_req(8'h08, 3);

    // All-request reset while issues are in flight.
    do_reset(2, 8'hFF);
    for (int i = 0; i < PIPE + 2; i++) cycle_req(8'h00, -1);

    chk("queue_drained", q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apu_shared_dispatch.md
APU_SHARED_DISPATCH -- requirements
Module: apu_shared_dispatch

Interface
REQ-001 SHALL have parameter NCORES, default 8, number of requesting cores (2..16).
REQ-002 SHALL have parameter PIPE_REGS, default C_ADDSUB_PIPE_REGS (1), fixed latency of the shared unit in cycles (1..8).
REQ-003 SHALL have parameter WOP, default WOP_ADDSUB (1), opcode width.
REQ-004 SHALL have parameters NDSFLAGS, default NDSFLAGS_ADDSUB (3), and NUSFLAGS, default NUSFLAGS_ADDSUB (8).
REQ-005 SHALL have port clk_i  in  1  clock; one clock domain.
REQ-006 SHALL have port rst_i  in  1  reset; synchronous, active-high.
REQ-007 SHALL have port core_req_i  in  NCORES  per-core request.
REQ-008 SHALL have port core_gnt_o  out  NCORES  per-core grant, one-hot or zero.
REQ-009 SHALL have ports core_opa_i, core_opb_i  in  NCORES x FP_WIDTH  operands.
REQ-010 SHALL have ports core_op_i  in  NCORES x WOP  opcode, and core_flags_i  in  NCORES x NDSFLAGS  downstream flags.
REQ-011 SHALL have port core_rvalid_o  out  NCORES  per-core result valid, one-hot or zero.
REQ-012 SHALL have ports core_result_o  out  FP_WIDTH and core_rflags_o  out  NUSFLAGS  broadcast result and flags.
REQ-013 SHALL have ports unit_valid_o  out  1, unit_opa_o, unit_opb_o  out  FP_WIDTH, unit_op_o  out  WOP, unit_flags_o  out  NDSFLAGS  issue to the shared unit.
REQ-014 SHALL have ports unit_result_i  in  FP_WIDTH and unit_flags_i  in  NUSFLAGS  unit output, valid PIPE_REGS cycles after issue.
REQ-015 SHALL have port busy_o  out  1  any operation in flight.

Function
REQ-016 SHALL grant at most one core per cycle, combinationally, in the cycle core_req_i is high; a grant is the accept handshake.
REQ-017 SHALL arbitrate round-robin: search starts at priority pointer ptr, wrapping NCORES-1 -> 0.
REQ-018 SHALL update ptr to (granted index + 1) mod NCORES at the clock edge after a grant; ptr SHALL hold when no grant.
REQ-019 SHALL assert unit_valid_o in the grant cycle and drive the unit ports from the granted core; all unit data ports SHALL be zero when no grant.
REQ-020 SHALL track each issue in a PIPE_REGS-deep shift register of {valid, core index}, advancing every cycle.
REQ-021 SHALL assert core_rvalid_o[k] exactly PIPE_REGS cycles after core k's grant, for one cycle; core_result_o/core_rflags_o SHALL pass unit_result_i/unit_flags_i through combinationally.
REQ-022 SHALL sustain one issue per cycle with no bubbles; back-to-back grants to the same core SHALL be allowed when it is the only requester.
REQ-023 SHALL drive busy_o high when any shift-register stage is valid.
REQ-024 Requests from a core SHALL be ignored in cycles where it is not granted; the core holds its request and operands until granted.

Reset
REQ-025 On rst_i SHALL clear ptr to 0 and all shift-register valids to 0; in-flight operations are dropped, and no core_rvalid_o SHALL fire for them.
REQ-026 During rst_i SHALL hold core_gnt_o, unit_valid_o, core_rvalid_o and busy_o at 0, regardless of core_req_i.

Structure
REQ-027 NCORES default, the pipeline-latency constants, and the WOP/NDSFLAGS/NUSFLAGS widths SHALL come from apu_cluster_package; no local redefinition.
REQ-028 The round-robin arbiter SHALL be a sub-module rr_arbiter (inputs req, ptr; output one-hot gnt and index); the tag shift register stays in apu_shared_dispatch.

Verification
REQ-029 Reset, then core_req_i=8'h01, opa=32'h3f800000, opb=32'h40000000 for 1 cycle -> gnt_o=8'h01 that cycle, rvalid_o=8'h01 exactly PIPE_REGS cycles later, ptr=1.
REQ-030 core_req_i=8'hFF held for 16 cycles from ptr=0 -> grants 0,1,...,7,0,...,7 in order; rvalid follows each grant by PIPE_REGS.
REQ-031 ptr=6, core_req_i=8'h41 -> core 6 granted, then core 0 (wrap), then core 6.
REQ-032 PIPE_REGS=5, three grants, then rst_i asserted for 1 cycle while in flight -> no core_rvalid_o afterwards; busy_o=0 the cycle after reset.
REQ-033 No requests for 10 cycles -> unit_valid_o=0, unit data ports=0, ptr unchanged, busy_o falls PIPE_REGS cycles after the last grant.
REQ-034 rst_i high with core_req_i=8'hFF -> core_gnt_o=0 and unit_valid_o=0 throughout reset.
